// File: rtl/mul_float_unpack_if.sv
// Operand/result handshake bundle for the mul_float_unpack front stage.
// slave is the stage's view; master is the upstream/downstream environment's view.
interface mul_float_unpack_if;
  logic        iDATA_VALID;
  logic        oDATA_BUSY;
  logic [31:0] iDATA_A;
  logic [31:0] iDATA_B;
  logic        oDATA_VALID;
  logic        iDATA_BUSY;
  logic        oDATA_SIGN;
  logic [9:0]  oDATA_EXP;
  logic [23:0] oDATA_FRACT_A;
  logic [23:0] oDATA_FRACT_B;
  logic        oDATA_EXCEPT_EXP_A0;
  logic        oDATA_EXCEPT_EXP_B0;
  logic        oDATA_EXCEPT_EXP_A1;
  logic        oDATA_EXCEPT_EXP_B1;
  logic        oDATA_EXCEPT_FRACT_A0;
  logic        oDATA_EXCEPT_FRACT_B0;

  modport slave (
    input  iDATA_VALID, iDATA_A, iDATA_B, iDATA_BUSY,
    output oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP,
           oDATA_FRACT_A, oDATA_FRACT_B,
           oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0,
           oDATA_EXCEPT_EXP_A1, oDATA_EXCEPT_EXP_B1,
           oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0
  );

  modport master (
    output iDATA_VALID, iDATA_A, iDATA_B, iDATA_BUSY,
    input  oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP,
           oDATA_FRACT_A, oDATA_FRACT_B,
           oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0,
           oDATA_EXCEPT_EXP_A1, oDATA_EXCEPT_EXP_B1,
           oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0
  );
endinterface

// File: rtl/mul_float_unpack.sv
// Binary32 multiplier front stage: unpacks sign, biased exponent sum, significands and
// exception flags into one registered stage. Define MUL_FLOAT_UNPACK_SKID_EN for a skid entry.
module mul_float_unpack #(
  parameter logic [9:0] P_BIAS       = 10'd127,
  parameter logic       P_DEN_HIDDEN = 1'b0
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iRESET_SYNC,
  mul_float_unpack_if.slave bus
);

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] fract_a;
    logic [23:0] fract_b;
    logic        exp_a0;
    logic        exp_b0;
    logic        exp_a1;
    logic        exp_b1;
    logic        fract_a0;
    logic        fract_b0;
  } beat_t;

  function automatic logic hidden_bit(input logic [7:0] e);
    return (e == 8'h00) ? P_DEN_HIDDEN : 1'b1;
  endfunction

  function automatic beat_t unpack(input logic [31:0] a, input logic [31:0] b);
    beat_t r;
    r.sign     = a[31] ^ b[31];
    // Ten bits leave room for both the underflow (bit9) and overflow (bit8) indications.
    r.exp      = {2'b00, a[30:23]} + {2'b00, b[30:23]} - P_BIAS;
    r.fract_a  = {hidden_bit(a[30:23]), a[22:0]};
    r.fract_b  = {hidden_bit(b[30:23]), b[22:0]};
    r.exp_a0   = (a[30:23] == 8'h00);
    r.exp_b0   = (b[30:23] == 8'h00);
    r.exp_a1   = (a[30:23] == 8'hff);
    r.exp_b1   = (b[30:23] == 8'hff);
    r.fract_a0 = (a[22:0] == 23'd0);
    r.fract_b0 = (b[22:0] == 23'd0);
    return r;
  endfunction

  beat_t in_beat;
  beat_t out_d, out_q;
  logic  valid_d, valid_q;

  assign in_beat = unpack(bus.iDATA_A, bus.iDATA_B);

`ifdef MUL_FLOAT_UNPACK_SKID_EN
  beat_t skid_d, skid_q;
  logic  skid_full_d, skid_full_q;
  logic  accept;

  assign accept = bus.iDATA_VALID && !skid_full_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    out_d       = out_q;
    valid_d     = valid_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (iRESET_SYNC) begin
      out_d       = '0;
      valid_d     = 1'b0;
      skid_d      = '0;
      skid_full_d = 1'b0;
    end else if (skid_full_q) begin
      if (!bus.iDATA_BUSY) begin
        out_d       = skid_q;
        valid_d     = 1'b1;
        skid_full_d = 1'b0;
      end
    end else if (accept && valid_q && bus.iDATA_BUSY) begin
      skid_d      = in_beat;
      skid_full_d = 1'b1;
    end else if (accept) begin
      out_d   = in_beat;
      valid_d = 1'b1;
    end else if (!bus.iDATA_BUSY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end

  // Busy is purely registered so upstream never sees a path from iDATA_BUSY.
  assign bus.oDATA_BUSY = skid_full_q;
`else
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (iRESET_SYNC) begin
      out_d   = '0;
      valid_d = 1'b0;
    end else if (!bus.iDATA_BUSY) begin
      out_d   = in_beat;
      valid_d = bus.iDATA_VALID;
    end
  end

  assign bus.oDATA_BUSY = bus.iDATA_BUSY;
`endif

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (iRESET) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.oDATA_VALID           = valid_q;
  assign bus.oDATA_SIGN            = out_q.sign;
  assign bus.oDATA_EXP             = out_q.exp;
  assign bus.oDATA_FRACT_A         = out_q.fract_a;
  assign bus.oDATA_FRACT_B         = out_q.fract_b;
  assign bus.oDATA_EXCEPT_EXP_A0   = out_q.exp_a0;
  assign bus.oDATA_EXCEPT_EXP_B0   = out_q.exp_b0;
  assign bus.oDATA_EXCEPT_EXP_A1   = out_q.exp_a1;
  assign bus.oDATA_EXCEPT_EXP_B1   = out_q.exp_b1;
  assign bus.oDATA_EXCEPT_FRACT_A0 = out_q.fract_a0;
  assign bus.oDATA_EXCEPT_FRACT_B0 = out_q.fract_b0;

endmodule
